tuple_collector: RTL and testbench
==================================

Name: tuple_collector

Overview:
Downstream consumer of the sum_zero triplet generator. It takes each 24-bit index triplet over a 4-phase valid/ack handshake and canonicalises it by sorting the three indices ascending. Sorted triplets are buffered in a small FIFO and emitted as a byte-serial stream with ready/valid flow control and a last-byte marker. It owns ack generation for the generator, and back-pressures it when the FIFO is full.

Parameters:
IDX_W, 8, width of one index field; tuple width is 3*IDX_W.
DEPTH, 8, FIFO depth in triplets; power of 2, minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
valid  input  1  triplet-available flag from generator (4-phase request)
tuple  input  3*IDX_W  triplet, fields a=[IDX_W-1:0], b=[2*IDX_W-1:IDX_W], c=[3*IDX_W-1:2*IDX_W]
ack  output  1  4-phase acknowledge to generator, registered
out_data  output  IDX_W  current serial index byte
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts out_data this cycle
out_last  output  1  out_data is the third (largest) index of a triplet
fifo_level  output  $clog2(DEPTH)+1  triplets stored, 0..DEPTH
tuple_count  output  8  triplets accepted since reset, saturates at 255

Behaviour:
- Reset (reset=0, async):
  - ack=0, out_valid=0, out_last=0, out_data=0, fifo_level=0, tuple_count=0.
  - FIFO pointers cleared, serializer byte index=0, handshake FSM=IDLE.
  - A partially serialized triplet is discarded.
- Handshake FSM, registered, states IDLE and ACKED:
  - IDLE: ack=0. If valid=1 and fifo_level<DEPTH at the clock edge, write the sorted tuple, increment tuple_count (saturating) and go to ACKED. ack is 1 from the next cycle, i.e. one cycle of latency.
  - IDLE with valid=1 and FIFO full: stay in IDLE and hold ack=0. Capture happens on the first edge where space exists.
  - ACKED: ack=1. Ignore tuple. Return to IDLE (ack=0 next cycle) on the first edge where valid=0.
  - Exactly one write per valid pulse. A new capture needs valid to be seen low first.
- Sort, combinational, before the write:
  - min/mid/max of a, b, c, unsigned compare.
  - Equal values allowed; the result is the same regardless of tie order.
  - Stored as min, mid, max.
- FIFO:
  - full = (fifo_level==DEPTH), computed from the registered level only. There is no same-cycle read-to-write bypass.
  - Simultaneous write and pop: fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
  - A write to an empty FIFO shows out_valid=1 on the cycle after the write edge.
- Serializer:
  - out_valid = (fifo_level!=0).
  - byte index k in 0..2 selects out_data = min, mid or max of the head entry. out_last = out_valid && k==2.
  - Transfer when out_valid && out_ready. k increments; at k==2 the transfer pops the head and sets k=0.
  - out_data, out_last and k are stable while out_valid=1 and out_ready=0.
- tuple_count stops at 255 and does not wrap.
- Reset asserted mid-handshake: ack drops asynchronously. After release, if valid is still 1, it is captured as a new triplet.

Test Plan:
1. Reset=0 for 2 cycles, then release with valid=0 -> every output is 0 and stays 0.
2. tuple={c=8'd1,b=8'd5,a=8'd3} with valid=1, out_ready=1 -> ack=1 one cycle after capture; valid dropped -> ack=0 the next cycle. Stream is 1, 3, 5 with out_last on 5; tuple_count=1.
3. Ties: tuple={c=7,b=0,a=7} -> stream 0, 7, 7, last on the second 7.
4. out_ready=0 while 9 triplets are offered back-to-back with 4-phase handshakes:
   - 8 are acked; the 9th holds valid with ack=0; fifo_level=8.
   - Raise out_ready for 3 transfers -> the 9th is acked within 2 cycles.
   - The final stream order matches arrival order.
5. out_ready toggling every cycle during a triplet -> out_data holds while stalled; the 3 bytes arrive in order; exactly one pop.
6. Reset=0 while ack=1 and the FIFO holds 3 triplets -> ack, out_valid and fifo_level drop immediately. After release, the held valid is captured once and tuple_count=1.

Source files
------------

// File: rtl/tuple_collector_if.sv
// Handshake bundle between the triplet generator, the collector and the
// byte-serial sink. The master side is the generator plus sink, the slave
// side is the collector itself.
interface tuple_collector_if #(
   parameter int IDX_W = 8
);
   logic               valid;
   logic [3*IDX_W-1:0] tuple;
   logic               ack;
   logic [IDX_W-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;

   modport master (
      output valid,
      output tuple,
      output out_ready,
      input  ack,
      input  out_data,
      input  out_valid,
      input  out_last
   );

   modport slave (
      input  valid,
      input  tuple,
      input  out_ready,
      output ack,
      output out_data,
      output out_valid,
      output out_last
   );
endinterface

// File: rtl/tuple_collector.sv
// Collects index triplets over a 4-phase valid/ack handshake, sorts each
// triplet ascending, queues it in a small FIFO and streams the three
// indices out one per transfer, flagging the largest as the last byte.
module tuple_collector #(
   parameter int IDX_W = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   tuple_collector_if.slave       bus,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [7:0]             tuple_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int TW = 3 * IDX_W;
   localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

   typedef enum logic {
      IDLE,
      ACKED
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [TW-1:0]     mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [1:0]        byte_idx;
   logic [IDX_W-1:0]  fa;
   logic [IDX_W-1:0]  fb;
   logic [IDX_W-1:0]  fc;
   logic [IDX_W-1:0]  lo_ab;
   logic [IDX_W-1:0]  hi_ab;
   logic [IDX_W-1:0]  s_min;
   logic [IDX_W-1:0]  s_mid;
   logic [IDX_W-1:0]  s_max;
   logic [TW-1:0]     head;
   logic              full;
   logic              wr_en;
   logic              xfer;
   logic              pop;

   assign fa = bus.tuple[IDX_W-1:0];
   assign fb = bus.tuple[2*IDX_W-1:IDX_W];
   assign fc = bus.tuple[3*IDX_W-1:2*IDX_W];

   // Three-input sort: order a/b first, then place c relative to that pair.
   always_comb begin
      lo_ab = (fa < fb) ? fa : fb;
      hi_ab = (fa < fb) ? fb : fa;
      s_min = (fc < lo_ab) ? fc : lo_ab;
      s_max = (fc > hi_ab) ? fc : hi_ab;
      if (fc < lo_ab)
         s_mid = lo_ab;
      else if (fc > hi_ab)
         s_mid = hi_ab;
      else
         s_mid = fc;
   end

   // Fullness comes from the registered level only, so a pop never frees a slot in the same cycle.
   assign full = (fifo_level == FULL_LEVEL);

   // Handshake next-state: capture once per valid pulse, then wait for valid to fall.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.valid && !full) begin
               wr_en   = 1'b1;
               state_d = ACKED;
            end
         end
         ACKED: begin
            if (!bus.valid)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake state register; ack is decoded straight from it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   assign bus.ack = (state_q == ACKED);

   assign bus.out_valid = (fifo_level != '0);
   assign xfer          = bus.out_valid && bus.out_ready;
   assign pop           = xfer && (byte_idx == 2'd2);
   assign head          = mem[rd_ptr];
   assign bus.out_last  = bus.out_valid && (byte_idx == 2'd2);

   // Pick the head entry's field for the current byte, zero when nothing is queued.
   always_comb begin
      bus.out_data = '0;
      if (bus.out_valid) begin
         unique case (byte_idx)
            2'd0:    bus.out_data = head[IDX_W-1:0];
            2'd1:    bus.out_data = head[2*IDX_W-1:IDX_W];
            2'd2:    bus.out_data = head[3*IDX_W-1:2*IDX_W];
            default: bus.out_data = '0;
         endcase
      end
   end

   // Storage array, written with the sorted triplet stored as {max, mid, min}.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {s_max, s_mid, s_min};
   end

   // Pointers, occupancy and the saturating acceptance counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         tuple_count <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (wr_en && (tuple_count != 8'hFF))
            tuple_count <= tuple_count + 8'd1;
      end
   end

   // Serializer byte index: advances per transfer and wraps on the popping transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         byte_idx <= 2'd0;
      else if (xfer)
         byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
   end

endmodule

// File: tb/tb_tuple_collector.sv
// Self-checking bench for tuple_collector: directed handshake/reset
// sequences, a constant vector table for the sort, and a randomized run
// checked against a queue-based model of the expected byte stream.
module tb_tuple_collector;

   localparam int BUDGET = 60;

   logic       clk;
   logic       reset;
   logic [3:0] fifo_level;
   logic [7:0] tuple_count;

   tuple_collector_if #(.IDX_W(8)) bus ();

   tuple_collector #(.IDX_W(8), .DEPTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .fifo_level  (fifo_level),
      .tuple_count (tuple_count)
   );

   typedef struct {
      int a;
      int b;
      int c;
      int lo;
      int md;
      int hi;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int model_count = 0;
   int exp_data[$];
   int exp_last[$];
   int rx_data[$];
   int rx_last[$];
   bit done;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Record each accepted output byte half a cycle before the edge that takes it.
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         rx_data.push_back(int'(bus.out_data));
         rx_last.push_back(int'(bus.out_last));
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a triplet leaves as its three values in ascending order, last on the third.
   task automatic push_sorted(input int a, input int b, input int c);
      int v[3];
      int t;
      v[0] = a; v[1] = b; v[2] = c;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      for (int i = 0; i < 3; i++) begin
         exp_data.push_back(v[i]);
         exp_last.push_back(i == 2 ? 1 : 0);
      end
      if (model_count < 255)
         model_count++;
   endtask

   task automatic wait_ack(input logic lvl, input string name);
      int n = 0;
      while (bus.ack !== lvl && n < BUDGET) begin
         step();
         n++;
      end
      check(name, int'(bus.ack), int'(lvl));
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      bus.tuple = {c, b, a};
      bus.valid = 1'b1;
      wait_ack(1'b1, "ack_rise");
      if (bus.ack === 1'b1) begin
         push_sorted(int'(a), int'(b), int'(c));
         check("tuple_count", int'(tuple_count), model_count);
      end
      bus.valid = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic drain();
      int n = 0;
      bus.out_ready = 1'b1;
      while (bus.out_valid === 1'b1 && n < 4 * BUDGET) begin
         step();
         n++;
      end
      check("drain_empty", int'(bus.out_valid), 0);
   endtask

   task automatic checkOutput(input string name);
      int n;
      check({name, "_len"}, rx_data.size(), exp_data.size());
      n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         check({name, "_data"}, rx_data[i], exp_data[i]);
         check({name, "_last"}, rx_last[i], exp_last[i]);
      end
      rx_data.delete(); rx_last.delete();
      exp_data.delete(); exp_last.delete();
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_ack"},   int'(bus.ack), 0);
      check({name, "_valid"}, int'(bus.out_valid), 0);
      check({name, "_last"},  int'(bus.out_last), 0);
      check({name, "_data"},  int'(bus.out_data), 0);
      check({name, "_level"}, int'(fifo_level), 0);
      check({name, "_count"}, int'(tuple_count), 0);
   endtask

   initial begin
      vec_t vecs[7];
      int   j;
      logic [7:0] ra, rb, rc, m;

      vecs[0] = '{3, 5, 1, 1, 3, 5};
      vecs[1] = '{7, 0, 7, 0, 7, 7};
      vecs[2] = '{255, 0, 128, 0, 128, 255};
      vecs[3] = '{9, 9, 9, 9, 9, 9};
      vecs[4] = '{200, 100, 150, 100, 150, 200};
      vecs[5] = '{0, 255, 255, 0, 255, 255};
      vecs[6] = '{4, 2, 2, 2, 2, 4};

      reset         = 1'b0;
      bus.valid     = 1'b0;
      bus.tuple     = '0;
      bus.out_ready = 1'b0;

      // Test 1: reset then idle
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("t1_in_reset");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle_outputs("t1_idle");
      end

      // Test 2: single triplet with cycle-exact handshake and stream
      bus.out_ready = 1'b1;
      bus.tuple     = {8'd1, 8'd5, 8'd3};
      bus.valid     = 1'b1;
      @(negedge clk);
      check("t2_ack_before", int'(bus.ack), 0);
      step();
      check("t2_ack_after", int'(bus.ack), 1);
      check("t2_level", int'(fifo_level), 1);
      check("t2_byte0", int'(bus.out_data), 1);
      check("t2_last0", int'(bus.out_last), 0);
      push_sorted(3, 5, 1);
      check("t2_count", int'(tuple_count), model_count);
      bus.valid = 1'b0;
      step();
      check("t2_ack_drop", int'(bus.ack), 0);
      check("t2_byte1", int'(bus.out_data), 3);
      check("t2_last1", int'(bus.out_last), 0);
      step();
      check("t2_byte2", int'(bus.out_data), 5);
      check("t2_last2", int'(bus.out_last), 1);
      step();
      check("t2_empty", int'(bus.out_valid), 0);
      check("t2_level_end", int'(fifo_level), 0);
      checkOutput("t2_stream");

      // Sort vector table, including ties and extremes
      for (int v = 0; v < 7; v++) begin
         applyStimulus(8'(vecs[v].a), 8'(vecs[v].b), 8'(vecs[v].c));
         drain();
         check("vec_len", rx_data.size(), 3);
         if (rx_data.size() == 3) begin
            check("vec_min", rx_data[0], vecs[v].lo);
            check("vec_mid", rx_data[1], vecs[v].md);
            check("vec_max", rx_data[2], vecs[v].hi);
            check("vec_last", rx_last[2], 1);
            check("vec_notlast", rx_last[1], 0);
         end
         rx_data.delete(); rx_last.delete();
         exp_data.delete(); exp_last.delete();
      end

      // Test 4: fill under back-pressure, ninth triplet waits for space
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         applyStimulus(8'(i * 3 + 2), 8'(i), 8'(40 - i));
      check("t4_full", int'(fifo_level), 8);
      bus.tuple = {8'd60, 8'd50, 8'd70};
      bus.valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_held_ack", int'(bus.ack), 0);
         check("t4_held_level", int'(fifo_level), 8);
      end
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      j = 0;
      while (bus.ack !== 1'b1 && j < 2) begin
         step();
         j++;
      end
      check("t4_ack_after_space", int'(bus.ack), 1);
      push_sorted(70, 50, 60);
      check("t4_count", int'(tuple_count), model_count);
      bus.valid = 1'b0;
      wait_ack(1'b0, "t4_ack_fall");
      drain();
      checkOutput("t4_stream");

      // Test 5: out_ready toggling mid-triplet
      bus.out_ready = 1'b0;
      applyStimulus(8'd30, 8'd10, 8'd20);
      applyStimulus(8'd6, 8'd4, 8'd5);
      j = 0;
      for (int cyc = 0; cyc < 20 && j < 3; cyc++) begin
         check("t5_data", int'(bus.out_data), exp_data[j]);
         check("t5_last", int'(bus.out_last), (j == 2) ? 1 : 0);
         bus.out_ready = (cyc % 2 == 0) ? 1'b1 : 1'b0;
         if (bus.out_ready)
            j++;
         step();
      end
      check("t5_bytes", j, 3);
      check("t5_one_pop", int'(fifo_level), 1);
      drain();
      checkOutput("t5_stream");

      // Test 6: reset while acked with three triplets queued
      bus.out_ready = 1'b0;
      applyStimulus(8'd11, 8'd12, 8'd13);
      applyStimulus(8'd21, 8'd22, 8'd23);
      bus.tuple = {8'd2, 8'd9, 8'd4};
      bus.valid = 1'b1;
      wait_ack(1'b1, "t6_ack_up");
      check("t6_level3", int'(fifo_level), 3);
      reset = 1'b0;
      #1;
      check("t6_ack_async", int'(bus.ack), 0);
      check("t6_valid_async", int'(bus.out_valid), 0);
      check("t6_level_async", int'(fifo_level), 0);
      exp_data.delete(); exp_last.delete();
      rx_data.delete(); rx_last.delete();
      model_count = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      wait_ack(1'b1, "t6_recapture");
      push_sorted(4, 9, 2);
      check("t6_count", int'(tuple_count), 1);
      bus.valid = 1'b0;
      wait_ack(1'b0, "t6_ack_fall");
      check("t6_count_once", int'(tuple_count), 1);
      drain();
      checkOutput("t6_stream");

      // Randomized run past the counter's saturation point
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 270; i++) begin
               m  = ($urandom % 2 == 0) ? 8'hFF : 8'h03;
               ra = 8'($urandom) & m;
               rb = 8'($urandom) & m;
               rc = 8'($urandom) & m;
               applyStimulus(ra, rb, rc);
               repeat ($urandom_range(0, 2)) step();
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               step();
               bus.out_ready = ($urandom % 4) != 0;
            end
         end
      join
      drain();
      check("rand_count_sat", int'(tuple_count), 255);
      checkOutput("rand_stream");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
